// File: rtl/segment_display.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Inputs are captured into shadow registers once per frame; all pins are registered.
module segment_display #(
  parameter int unsigned frequency      = 100000000,
  parameter int unsigned scan_frequency = 8000,
  parameter int unsigned blank_cycles   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] digits,
  input  logic [7:0]  dots,
  input  logic [7:0]  enable,
  output logic [7:0]  digit_sel_n,
  output logic [7:0]  segment_n,
  output logic        frame_start
);

  localparam int unsigned DIVISOR = frequency / scan_frequency;
  localparam int unsigned CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  if (DIVISOR < 2 || blank_cycles < 1 || blank_cycles >= DIVISOR) begin : g_bad_params
    $error("segment_display: need divisor >= 2 and 1 <= blank_cycles < divisor");
  end

  logic [CW-1:0] c_q, c_d;
  logic [2:0]    s_q, s_d;
  logic [31:0]   nib_q;
  logic [7:0]    dot_q;
  logic [7:0]    en_q;
  logic [7:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic          fs_q;

  logic          slot_last;
  logic          capture;
  logic          blank;
  logic [3:0]    nibble;
  logic [6:0]    pattern;

  always_comb begin
    slot_last = (c_q == CW'(DIVISOR - 1));
    c_d       = slot_last ? '0 : c_q + 1'b1;
    s_d       = slot_last ? s_q + 3'd1 : s_q;
    capture   = (c_q == '0) && (s_q == '0);
    nibble    = nib_q[{s_q, 2'b00} +: 4];

    unique case (nibble)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      default: pattern = 7'h71;
    endcase

    // Slot start is always blank, so capturing at c == 0 never shows a half-updated digit.
    blank = (c_q < CW'(blank_cycles)) || !en_q[s_q];
    sel_d = blank ? '1 : ~(8'b1 << s_q);
    seg_d = blank ? '1 : ~{dot_q[s_q], pattern};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      c_q   <= '0;
      s_q   <= '0;
      nib_q <= '0;
      dot_q <= '0;
      en_q  <= '0;
      sel_q <= '1;
      seg_q <= '1;
      fs_q  <= 1'b0;
    end else begin
      c_q   <= c_d;
      s_q   <= s_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
      fs_q  <= capture;
      if (capture) begin
        nib_q <= digits;
        dot_q <= dots;
        en_q  <= enable;
      end
    end
  end

  assign digit_sel_n = sel_q;
  assign segment_n   = seg_q;
  assign frame_start = fs_q;

endmodule
